ifetch_unit: RTL
================

# ifetch_unit

Instruction fetch front-end that produces the instruction stream the CPU controller decodes. It issues word reads to instruction memory over a single-outstanding req/ack interface and buffers returned words in a small FIFO. It presents them to decode with a valid/ready handshake, including the 5-bit `op` field. It also accepts branch/jump redirects from the execute stage, which flush the buffer and discard any in-flight response.

## Interface
- `n`, 32: instruction and address width; must be a multiple of 8 and at least 8.
- `DEPTH`, 2: instruction buffer entries; must be a power of two and at least 2.
- `RESET_PC`, 0: fetch address after reset; must be a multiple of 4.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `imem_req` out 1: read request, registered.
- `imem_addr` out n: read word address, registered; stable while `imem_req`=1.
- `imem_ack` in 1: response strobe, exactly one per request; data valid in the same cycle.
- `imem_rdata` in n: read data, sampled when `imem_ack`=1.
- `redirect` in 1: taken branch or jump, one-cycle pulse.
- `redirect_pc` in n: new fetch address; bits [1:0] are ignored and forced to 0.
- `instr_valid` out 1: buffer head is valid.
- `dec_ready` in 1: decode accepts the head this cycle.
- `instr` out n: head instruction; 0 when `instr_valid`=0.
- `op` out 5: `instr[n-1:n-5]`; 0 when `instr_valid`=0.
- `pc_out` out n: address of the head instruction; 0 when `instr_valid`=0.

## Operation
- Registers:
  - `fetch_pc`: address of the next request.
  - FIFO of {address, word}: `DEPTH` entries, with read/write pointers and a count.
  - FSM state.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; data will be kept.
  - DISCARD: request outstanding; data will be dropped.
- Pop: occurs when `instr_valid & dec_ready`.
- Push: occurs when `imem_ack` arrives in WAIT and there is no `redirect` in the same cycle.
- Space condition for issuing a request: count + push − pop < `DEPTH`. Counting the outstanding slot guarantees a returned word never overflows the buffer.
- IDLE transitions:
  - If space is available: `imem_req`←1, `imem_addr`←`fetch_pc`, go to WAIT.
- WAIT transitions:
  - `imem_ack` without redirect: push, `fetch_pc`←`fetch_pc`+4.
    - If space is still available, issue the next request immediately: `imem_addr`←new `fetch_pc`, `imem_req` stays 1, stay in WAIT.
    - Otherwise `imem_req`←0 and go to IDLE.
  - `redirect` without `imem_ack`: go to DISCARD; `imem_req` and `imem_addr` are held until the ack.
- DISCARD transitions:
  - On `imem_ack`: drop the data, `imem_req`←0, go to IDLE.
- Redirect (any state) has priority over push and pop:
  - FIFO is flushed (count←0, pointers←0).
  - `fetch_pc`←{`redirect_pc`[n-1:2], 2'b00}.
  - A pop in the same cycle is cancelled, and `instr_valid` is 0 the next cycle.
  - In IDLE: stay in IDLE; a request to the new PC issues the next cycle.
  - Simultaneous `redirect` and `imem_ack` in WAIT: the data is dropped and the FSM goes to IDLE; it does not enter DISCARD.
  - Redirect while in DISCARD: `fetch_pc` updates again; the FSM stays in DISCARD.
- Pointer arithmetic: pointers are log2(`DEPTH`) bits wide and wrap naturally. Count is log2(`DEPTH`)+1 bits. Address increment is modulo 2^n.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Full (count=`DEPTH`): no request is issued; `imem_req` is 0 unless the last request is still outstanding.
- Empty: `instr_valid`=0; `dec_ready` is ignored.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instr_valid`=0, `instr`=0, `op`=0, `pc_out`=0.
  - `fetch_pc`=`RESET_PC`, FIFO empty, state IDLE.
- Reset asserted mid-operation: all of the above take effect immediately, and any outstanding request is abandoned. The memory model is also reset.
- First request: `imem_req`=1 on the first rising edge after `reset` deasserts.
- Fetch latency: an `imem_ack` in cycle k gives `instr_valid`=1 with that word in cycle k+1.
- Zero-wait memory (ack in the same cycle as req) with `dec_ready`=1: sustained throughput is one instruction per cycle.
- Redirect in cycle k:
  - Request for `redirect_pc` issues no earlier than cycle k+1, or later if DISCARD waits on the old ack.
  - First redirected instruction is valid no earlier than cycle k+2.
- Head outputs are combinational from the FIFO and valid throughout the cycle.

## Test plan
- Reset, then zero-wait memory returning word A+0x1000 for address A, with `dec_ready`=1:
  - `imem_req` rises the first cycle after reset release.
  - Decode sees `pc_out`=0,4,8,… on consecutive cycles with `instr`=0x1000,0x1004,….
  - `op` equals `instr[31:27]`.
- Hold `dec_ready`=0 with zero-wait memory:
  - Exactly `DEPTH`=2 words are accepted, then `imem_req`=0.
  - Releasing `dec_ready` drains 0 then 4, and fetching resumes at 8 with no skipped or duplicated PC.
- Three-cycle memory latency; pulse `redirect` with `redirect_pc`=0x43 while in WAIT on address 8:
  - The late data for 8 is discarded.
  - Next `imem_addr`=0x40, and the next `pc_out`=0x40.
- `redirect` in the same cycle as `imem_ack` for address 4, with `redirect_pc`=0x80:
  - The word at 4 never becomes valid; the next request is to 0x80.
  - Redirect plus a concurrent pop with 2 buffered entries leaves `instr_valid`=0 the next cycle.
- Assert `reset` asynchronously mid-stream, with count=1 and a request outstanding:
  - Outputs go to reset values before the next edge.
  - After release, fetch restarts at `RESET_PC`.
- `RESET_PC`=0xFFFFFFFC:
  - The second fetch address wraps to 0x00000000.
  - The FIFO pointers wrap correctly over 10 or more push/pop cycles.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: single-outstanding imem reads, DEPTH-entry
// {pc, word} buffer, valid/ready head to decode, redirect flush.
// Ports: clk, reset (async, active-high)
//   imem_req/imem_addr -> memory; imem_ack/imem_rdata <- memory
//   redirect/redirect_pc <- execute
//   instr_valid/instr/op/pc_out -> decode; dec_ready <- decode
module ifetch_unit #(
  parameter int n = 32,
  parameter int DEPTH = 2,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [n-1:0] imem_rdata,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,
  output logic         instr_valid,
  input  logic         dec_ready,
  output logic [n-1:0] instr,
  output logic [4:0]   op,
  output logic [n-1:0] pc_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t state, state_nx;

  logic [n-1:0]  fetch_pc;
  logic [n-1:0]  fetch_pc_inc;
  logic [n-1:0]  redirect_aligned;
  logic [n-1:0]  buf_pc   [DEPTH];
  logic [n-1:0]  buf_word [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   level;
  logic          push;
  logic          pop;
  logic          space;
  logic          req_nx;
  logic [n-1:0]  addr_nx;

  assign fetch_pc_inc     = fetch_pc + n'(4);
  assign redirect_aligned = redirect_pc & ~n'(3);

  // A redirect cancels both the pop and the push of its cycle.
  assign instr_valid = (count != '0);
  assign pop  = instr_valid & dec_ready & ~redirect;
  assign push = (state == S_WAIT) & imem_ack & ~redirect;

  // Occupancy after this cycle; a new request reserves one more slot.
  assign level = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
  assign space = level < (CW+1)'(DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (!redirect && space) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack)
          state_nx = (!redirect && space) ? S_WAIT : S_IDLE;
        else if (redirect)
          state_nx = S_DISCARD;
      end
      S_DISCARD: begin
        if (imem_ack) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_nx  = imem_req;
    addr_nx = imem_addr;
    unique case (state)
      S_IDLE: begin
        if (!redirect && space) begin
          req_nx  = 1'b1;
          addr_nx = fetch_pc;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          if (!redirect && space) addr_nx = fetch_pc_inc;
          else                    req_nx  = 1'b0;
        end
      end
      S_DISCARD: begin
        if (imem_ack) req_nx = 1'b0;
      end
      default: req_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      imem_req  <= req_nx;
      imem_addr <= addr_nx;
      if (redirect) begin
        fetch_pc <= redirect_aligned;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          fetch_pc <= fetch_pc_inc;
          wr_ptr   <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Payload storage needs no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]   <= imem_addr;
      buf_word[wr_ptr] <= imem_rdata;
    end
  end

  assign instr  = instr_valid ? buf_word[rd_ptr] : '0;
  assign pc_out = instr_valid ? buf_pc[rd_ptr]   : '0;
  assign op     = instr[n-1:n-5];

endmodule
